pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl
//   Program-counter sequencer for a small microcoded controller. It starts
//   fetching at address 0, then increments, jumps, branches or halts as the
//   decoded instruction at the current address requests.
//
//   Optional feature: define PC_CALL_STACK_EN to add a STK_DEPTH-entry return
//   stack for call/ret. When it is undefined, call and ret are ignored and
//   stk_err stays 0. The port list is the same in both builds.
//
// Parameters
//   D          program-counter / jump-target width
//   STK_DEPTH  return-stack entries (PC_CALL_STACK_EN builds only)
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      leave IDLE/DONE and begin fetching at address 0
//   stall      hold PC and state for this cycle (highest priority)
//   halt       halt instruction at the current PC: hold PC and enter DONE
//   jump_abs   unconditional jump to target
//   branch     jump to target when cond=1
//   cond       branch condition flag
//   call, ret  subroutine call / return
//   target     absolute jump address
//   prog_ctr   current fetch address (registered)
//   running    high in RUN (registered)
//   done       high in DONE (registered)
//   stk_err    sticky return-stack overflow/underflow flag
// ----------------------------------------------------------------------------
// state  | meaning
// S_IDLE | after reset, PC held at 0, waiting for start
// S_RUN  | fetching; PC advances every non-stalled cycle
// S_DONE | halted; PC holds the halting address until start
// ----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int D         = 12,
    parameter int STK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         stall,
    input  logic         halt,
    input  logic         jump_abs,
    input  logic         branch,
    input  logic         cond,
    input  logic         call,
    input  logic         ret,
    input  logic [D-1:0] target,
    output logic [D-1:0] prog_ctr,
    output logic         running,
    output logic         done,
    output logic         stk_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t       r_state, w_state_nxt;
    logic [D-1:0] r_pc, w_pc_nxt, w_pc_inc;
    logic         r_running, r_done, r_err, w_err_nxt;
    logic         w_call, w_ret;

    // Natural D-bit overflow gives the required modulo-2^D wrap.
    assign w_pc_inc = r_pc + D'(1);

`ifdef PC_CALL_STACK_EN
    localparam int SPW = $clog2(STK_DEPTH + 1);
    localparam int IW  = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    logic [D-1:0]   r_stk [STK_DEPTH];
    logic [SPW-1:0] r_sp, w_sp_nxt;
    logic           w_push, w_full, w_empty;
    logic [IW-1:0]  w_wr_idx, w_rd_idx;

    assign w_call   = call;
    assign w_ret    = ret;
    assign w_full   = (r_sp == SPW'(STK_DEPTH));
    assign w_empty  = (r_sp == '0);
    assign w_wr_idx = IW'(r_sp);
    assign w_rd_idx = IW'(r_sp - SPW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sp <= '0;
        else          r_sp <= w_sp_nxt;
    end

    // Stack contents need no reset: they are unreachable while r_sp is 0.
    always_ff @(posedge clk) begin
        if (w_push) r_stk[w_wr_idx] <= w_pc_inc;
    end
`else
    logic w_unused_stk;
    assign w_call       = 1'b0;
    assign w_ret        = 1'b0;
    assign w_unused_stk = call ^ ret ^ (STK_DEPTH < 0);
`endif

    // State register plus registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
            r_err     <= w_err_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (!stall && halt) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next-PC / stack / error logic.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_err_nxt = r_err;
`ifdef PC_CALL_STACK_EN
        w_sp_nxt  = r_sp;
        w_push    = 1'b0;
`endif
        case (r_state)
            S_IDLE: w_pc_nxt = '0;
            S_DONE: if (start) w_pc_nxt = '0;
            S_RUN: begin
                if (stall || halt) begin
                    w_pc_nxt = r_pc;
                end else if (w_ret) begin
`ifdef PC_CALL_STACK_EN
                    if (w_empty) begin
                        w_pc_nxt  = w_pc_inc;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = r_stk[w_rd_idx];
                        w_sp_nxt = r_sp - SPW'(1);
                    end
`endif
                end else if (w_call) begin
                    w_pc_nxt = target;
`ifdef PC_CALL_STACK_EN
                    // A full stack still takes the call; only the push is lost.
                    if (w_full) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_push   = 1'b1;
                        w_sp_nxt = r_sp + SPW'(1);
                    end
`endif
                end else if (jump_abs || (branch && cond)) begin
                    w_pc_nxt = target;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            default: w_pc_nxt = '0;
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        prog_ctr = r_pc;
        running  = r_running;
        done     = r_done;
        stk_err  = r_err;
    end

endmodule
